// File: rtl/sevenseg_pkg.sv
// Shared widths and FSM state encoding for the seven-segment display arbiter.
// The display driver uses the same digit and decimal-place widths.
// No optional features in this file.
package sevenseg_pkg;
    localparam int NDIG    = 4;
    localparam int DIGIT_W = 4;
    localparam int DP_W    = 2;
    localparam int VAL_W   = NDIG * DIGIT_W;

    // IDLE: no owner; HOLD: owner locked while counter runs; OWN: owner replaceable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_t;
endpackage

// File: rtl/sevenseg_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr+1, with wrap.
// Ports: req (requests), ptr (last winner) -> win (one-hot), win_idx (binary), any (some bit set).
// Purely combinational, no state.
module sevenseg_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            any
);
    int idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // ptr itself is scanned last, so the previous winner has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_idx  = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/sevenseg_arbiter.sv
// Shares one 4-digit seven-segment driver among NREQ requesters: round-robin grant with minimum hold.
// Ports: clk, rst (async active-high), req/req_val/req_dp per requester -> grant, busy, digit0..3, decplace.
// Define SEGARB_FAIRNESS_EN to let other requesters preempt an owner whose hold time has expired.
module sevenseg_arbiter
    import sevenseg_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2**24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*VAL_W-1:0] req_val,
    input  logic [NREQ*DP_W-1:0] req_dp,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [DIGIT_W-1:0]   digit0,
    output logic [DIGIT_W-1:0]   digit1,
    output logic [DIGIT_W-1:0]   digit2,
    output logic [DIGIT_W-1:0]   digit3,
    output logic [DP_W-1:0]      decplace
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_INIT  = PW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_d;

    logic [NREQ-1:0] pick_req, pick_win;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            owner_req;
    logic            take_new, go_idle;

    // In OWN only the other requesters compete; the owner is excluded.
    assign pick_req  = (state_q == ST_OWN) ? (req & ~grant) : req;
    assign owner_req = |(grant & req);
    assign busy      = |grant;

    sevenseg_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (pick_req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant;
        take_new = 1'b0;
        go_idle  = 1'b0;
        case (state_q)
            ST_IDLE: take_new = pick_any;
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_OWN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_OWN: begin
`ifdef SEGARB_FAIRNESS_EN
                if (pick_any)        take_new = 1'b1;
                else if (!owner_req) go_idle  = 1'b1;
`else
                if (!owner_req) begin
                    if (pick_any) take_new = 1'b1;
                    else          go_idle  = 1'b1;
                end
`endif
            end
            default: go_idle = 1'b1;
        endcase
        // Switching owners goes straight to HOLD with no idle cycle in between.
        if (take_new) begin
            grant_d = pick_win;
            ptr_d   = pick_idx;
            cnt_d   = HOLD_INIT;
            state_d = ST_HOLD;
        end else if (go_idle) begin
            grant_d = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_INIT;
            grant   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
        end
    end

    // ptr_q always holds the current owner's index while grant is nonzero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {digit3, digit2, digit1, digit0} <= '0;
            decplace                         <= '0;
        end else if (owner_req) begin
            {digit3, digit2, digit1, digit0} <= req_val[ptr_q*VAL_W +: VAL_W];
            decplace                         <= req_dp[ptr_q*DP_W +: DP_W];
        end
    end
endmodule

// File: tb/tb_sevenseg_arbiter.sv
// Bench for sevenseg_arbiter (NREQ=4, HOLD_CYCLES=4): directed scenarios with literal expectations,
// then random requests; every cycle the DUT is compared with an ownership/age reference model.
// Works with or without SEGARB_FAIRNESS_EN defined.
module tb_sevenseg_arbiter;
    localparam int NR   = 4;
    localparam int HOLD = 4;

    logic          clk, rst;
    logic [NR-1:0] req;
    logic [NR*16-1:0] req_val;
    logic [NR*2-1:0]  req_dp;
    logic [NR-1:0] grant;
    logic          busy;
    logic [3:0]    digit0, digit1, digit2, digit3;
    logic [1:0]    decplace;

    int checks = 0;
    int failures = 0;

    sevenseg_arbiter #(.NREQ(NR), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .req_val(req_val), .req_dp(req_dp),
        .grant(grant), .busy(busy), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3), .decplace(decplace)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the display, how many edges since grant, last winner, shown value.
    int          m_owner;
    int          m_age;
    int          m_ptr;
    int          m_w;
    logic [15:0] m_disp;
    logic [1:0]  m_dp;
    logic [NR-1:0] m_others;

    function automatic int pick(input logic [NR-1:0] mask, input int from);
        int idx;
        for (int k = 1; k <= NR; k++) begin
            idx = (from + k) % NR;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = NR - 1; m_disp = '0; m_dp = '0;
        end else begin
            if (m_owner >= 0 && req[m_owner]) begin
                m_disp = req_val[m_owner*16 +: 16];
                m_dp   = req_dp[m_owner*2 +: 2];
            end
            if (m_owner < 0) begin
                m_w = pick(req, m_ptr);
                if (m_w >= 0) begin m_owner = m_w; m_ptr = m_w; m_age = 0; end
            end else if (m_age < HOLD) begin
                // Locked for HOLD edges after the grant, then one edge in the replaceable state.
                m_age++;
            end else begin
                m_others = req;
                m_others[m_owner] = 1'b0;
`ifdef SEGARB_FAIRNESS_EN
                if (m_others != '0) begin
                    m_w = pick(m_others, m_ptr); m_owner = m_w; m_ptr = m_w; m_age = 0;
                end else if (!req[m_owner]) m_owner = -1;
`else
                if (!req[m_owner]) begin
                    if (m_others != '0) begin
                        m_w = pick(m_others, m_ptr); m_owner = m_w; m_ptr = m_w; m_age = 0;
                    end else m_owner = -1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("model_grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_digits", 32'({digit3, digit2, digit1, digit0}), 32'(m_disp));
        check("model_dp", 32'(decplace), 32'(m_dp));
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_val = '0; req_dp = '0;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_digits", 32'({digit3, digit2, digit1, digit0}), 32'd0);
        rst = 1'b0;

        // Single requester, then release to idle after the hold has expired.
        @(negedge clk);
        req = 4'b0100; req_val[47:32] = 16'h1A3F; req_dp[5:4] = 2'd2;
        @(negedge clk);
        check("single_grant", 32'(grant), 32'h4);
        @(negedge clk);
        check("single_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1A3F);
        check("single_dp", 32'(decplace), 32'd2);
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1A3F);

        // Hold lock: owner 1 drops after one cycle, requester 3 waits out the hold.
        do_reset();
        req = 4'b0010; req_val[31:16] = 16'hBEEF; req_val[63:48] = 16'h7777;
        @(negedge clk);
        check("lock_grant0", 32'(grant), 32'h2);
        @(negedge clk);
        req = 4'b1000;
        // Four HOLD cycles plus the OWN cycle in which the switch is decided.
        for (int i = 1; i < 5; i++) begin
            check("lock_grant", 32'(grant), 32'h2);
            check("lock_digits", 32'({digit3, digit2, digit1, digit0}), 32'hBEEF);
            @(negedge clk);
        end
        check("lock_switch", 32'(grant), 32'h8);
        check("lock_digits_old", 32'({digit3, digit2, digit1, digit0}), 32'hBEEF);
        @(negedge clk);
        check("lock_digits_new", 32'({digit3, digit2, digit1, digit0}), 32'h7777);

        // Async reset mid-HOLD clears everything within the cycle.
        do_reset();
        req = 4'b0010;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_digits", 32'({digit3, digit2, digit1, digit0}), 32'd0);
        @(negedge clk);
        rst = 1'b0; req = '0;

        // Wrap: from pointer 3 requester 0 wins; from pointer 0 requester 3 wins.
        do_reset();
        req = 4'b1001;
        @(negedge clk);
        check("wrap_from3", 32'(grant), 32'h1);
        repeat (4) @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        check("wrap_from0", 32'(grant), 32'h8);

        // All requesting continuously.
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        check("rr_first", 32'(grant), 32'h1);
`ifdef SEGARB_FAIRNESS_EN
        repeat (5) @(negedge clk);
        check("rr_second", 32'(grant), 32'h2);
        repeat (5) @(negedge clk);
        check("rr_third", 32'(grant), 32'h4);
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rr_stay", 32'(grant), 32'h1);
        end
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = NR'($urandom_range(0, 15));
            req_val = {$urandom, $urandom};
            req_dp  = NR*2'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
